branch_target_predictor: RTL and testbench
==========================================

Name: branch_target_predictor

Overview:
- Parametrised branch target buffer (BTB) with per-entry saturating direction counters. It supersedes the fixed "predict not taken, flush on miss" scheme in the pipeline top.
- Sits beside the IF stage: combinational lookup on the fetch PC; registered update from ID, where the branch resolves early.
- Adds configurable depth and counter width, a one-cycle flush, performance counters, and an optional gshare indexing mode.

Parameters:
- ADDR_W, 32, PC/target width in bits.
- ENTRIES, 16, table depth; power of 2, ≥2. IDX_W = log2(ENTRIES).
- CTR_W, 2, direction counter width in bits, range 1..4.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  pipeline stall (ICACHE_stall|DCACHE_stall); freezes all state
- flush  in  1  invalidate whole table
- lk_pc  in  ADDR_W  fetch PC
- lk_hit  out  1  valid entry with tag match
- lk_taken  out  1  predicted taken
- lk_target  out  ADDR_W  predicted next PC
- lk_ghr  out  IDX_W  history snapshot for this lookup; 0 without macro
- upd_valid  in  1  resolved branch present in ID
- upd_pc  in  ADDR_W  PC of resolved branch
- upd_ghr  in  IDX_W  lk_ghr carried down with the branch
- upd_taken  in  1  actual direction
- upd_target  in  ADDR_W  actual taken target
- upd_mispredict  in  1  pipeline flagged a mispredict (PredictMiss)
- stat_upd  out  32  count of accepted updates
- stat_miss  out  32  count of accepted mispredicts

Behaviour:
- Entry fields: valid, tag = pc[ADDR_W-1:IDX_W+2], target[ADDR_W], ctr[CTR_W]. Storage is flops.
- Index: idx = pc[IDX_W+1:2]. With the macro, XOR with the ghr per the optional feature.
- Lookup (combinational, 0 latency):
  - lk_hit = valid[idx] && tag match.
  - lk_taken = lk_hit && ctr[idx] MSB.
  - lk_target = lk_taken ? target[idx] : lk_pc+4, truncated to ADDR_W (wraps at top).
- Accepted update: upd_valid && !stall && !flush && !rst. Takes effect at the next edge.
- Update on a hit (same tag, via upd_pc/upd_ghr index):
  - ctr saturating +1 if taken, −1 if not taken. It holds at all-ones / zero.
  - target written only when taken.
- Update on a miss:
  - If taken: allocate (overwrite) the entry with valid=1, new tag, upd_target, ctr = weakly taken (MSB=1, rest 0).
  - If not taken: no change.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents.
- flush (not stalled): all valid=0 next edge; ctr and target untouched; beats any update. Stats unchanged.
- stall: no table, ghr or stat change; lookup outputs remain live.
- Stats, on accepted updates:
  - stat_upd += 1.
  - stat_miss += upd_mispredict.
  - Both wrap modulo 2^32, silently.
- Reset (sync, highest priority):
  - valid=0.
  - ctr = weakly not taken (MSB=0, rest 1; for CTR_W=1, 0).
  - target=0, ghr=0, stat_upd=0, stat_miss=0.
  - Lookup outputs after reset: lk_hit=0, lk_taken=0, lk_target=lk_pc+4.
- CTR_W=1: counter is a last-outcome bit.

Optional Feature:
- Macro: BTP_GSHARE_EN.
- Defined:
  - IDX_W-bit global history register, ghr.
  - Lookup idx = pc[IDX_W+1:2] ^ ghr; lk_ghr = ghr.
  - Update idx = upd_pc[IDX_W+1:2] ^ upd_ghr.
  - On each accepted update, ghr <= {ghr[IDX_W-2:0], upd_taken}; for IDX_W=1, ghr <= upd_taken.
  - flush does not clear ghr; rst does.
- Undefined:
  - No ghr register; lk_ghr tied to 0.
  - upd_ghr ignored; pure PC indexing.

Test Plan:
- Reset, then lk_pc=0x00400010 -> lk_hit=0, lk_taken=0, lk_target=0x00400014; stat_upd=stat_miss=0.
- Update pc=0x00400010, taken, target=0x00400100, mispredict=1; next cycle lookup same pc -> lk_hit=1, lk_taken=1, lk_target=0x00400100, ctr=2'b10, stat_miss=1.
- Saturation, same pc: 3 taken updates -> ctr=2'b11 and stays there. Then 2 not-taken updates -> ctr=2'b01, lk_taken=0, lk_hit=1, lk_target=pc+4.
- Alias: pc 0x00400010 and 0x00400050 share idx 4 (ENTRIES=16). Taken update of 0x50 evicts 0x10 -> lookup of 0x10 gives lk_hit=0. A not-taken miss update of 0x90 leaves the entry unchanged.
- Simultaneous events:
  - stall=1 with upd_valid=1 -> no table/stat change.
  - flush=1 with upd_valid=1 -> all entries invalid, stat_upd unchanged.
  - rst asserted mid-sequence -> all stats 0 next cycle.
- With BTP_GSHARE_EN: ghr=0 -> taken update at pc 0x00400010 sets ghr=0001. A lookup of the same pc now indexes entry 5 (miss). An update with upd_ghr=0 trains entry 4. Stat wrap: preload via 2^32 updates (forced) -> stat_upd wraps to 0.

Source files
------------

// File: rtl/branch_target_predictor.sv
// Branch target buffer with per-entry saturating direction counters, sitting beside IF.
// Define BTP_GSHARE_EN to XOR a global history register into the table index (gshare).
module branch_target_predictor #(
   parameter int ADDR_W  = 32,
   parameter int ENTRIES = 16,
   parameter int CTR_W   = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         stall,
   input  logic                         flush,
   input  logic [ADDR_W-1:0]            lk_pc,
   output logic                         lk_hit,
   output logic                         lk_taken,
   output logic [ADDR_W-1:0]            lk_target,
   output logic [$clog2(ENTRIES)-1:0]   lk_ghr,
   input  logic                         upd_valid,
   input  logic [ADDR_W-1:0]            upd_pc,
   input  logic [$clog2(ENTRIES)-1:0]   upd_ghr,
   input  logic                         upd_taken,
   input  logic [ADDR_W-1:0]            upd_target,
   input  logic                         upd_mispredict,
   output logic [31:0]                  stat_upd,
   output logic [31:0]                  stat_miss
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = ADDR_W - IDX_W - 2;

   localparam logic [CTR_W-1:0] CTR_ZERO = {CTR_W{1'b0}};
   localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
   localparam logic [CTR_W-1:0] CTR_WT   = CTR_W'(1) << (CTR_W - 1);
   localparam logic [CTR_W-1:0] CTR_WNT  = CTR_WT - CTR_W'(1);

   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [TAG_W-1:0]   tag_d    [ENTRIES];
   logic [ADDR_W-1:0]  target_q [ENTRIES];
   logic [ADDR_W-1:0]  target_d [ENTRIES];
   logic [CTR_W-1:0]   ctr_q    [ENTRIES];
   logic [CTR_W-1:0]   ctr_d    [ENTRIES];
   logic [31:0]        stat_upd_q, stat_upd_d;
   logic [31:0]        stat_miss_q, stat_miss_d;

   logic [IDX_W-1:0]   lk_idx_s;
   logic [IDX_W-1:0]   upd_idx_s;
   logic [TAG_W-1:0]   upd_tag_s;
   logic               upd_hit_s;
   logic               accept_s;
   logic [CTR_W-1:0]   ctr_cur_s;
   logic [CTR_W-1:0]   ctr_nxt_s;

   assign accept_s  = upd_valid && !stall && !flush && !rst;
   assign upd_tag_s = upd_pc[ADDR_W-1:IDX_W+2];

`ifdef BTP_GSHARE_EN
   logic [IDX_W-1:0] ghr_q;

   assign lk_idx_s  = lk_pc[IDX_W+1:2] ^ ghr_q;
   assign upd_idx_s = upd_pc[IDX_W+1:2] ^ upd_ghr;
   assign lk_ghr    = ghr_q;

   // Global history shift register; survives flush, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         ghr_q <= {IDX_W{1'b0}};
      end else if (accept_s) begin
         ghr_q <= IDX_W'({ghr_q, upd_taken});
      end else begin
         ghr_q <= ghr_q;
      end
   end
`else
   logic unused_ghr_s;

   assign lk_idx_s     = lk_pc[IDX_W+1:2];
   assign upd_idx_s    = upd_pc[IDX_W+1:2];
   assign lk_ghr       = {IDX_W{1'b0}};
   assign unused_ghr_s = ^upd_ghr;
`endif

   // Word alignment bits of the resolved PC never reach the table.
   logic unused_pc_s;
   assign unused_pc_s = ^upd_pc[1:0];

   // Zero-latency lookup on the fetch PC; fall-through is pc+4, wrapping at the top.
   always_comb begin
      lk_hit    = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == lk_pc[ADDR_W-1:IDX_W+2]);
      lk_taken  = lk_hit && ctr_q[lk_idx_s][CTR_W-1];
      lk_target = lk_taken ? target_q[lk_idx_s] : (lk_pc + ADDR_W'(4));
   end

   // Saturating direction counter step for the entry being trained.
   always_comb begin
      ctr_cur_s = ctr_q[upd_idx_s];
      if (upd_taken) begin
         ctr_nxt_s = (ctr_cur_s == CTR_MAX) ? ctr_cur_s : (ctr_cur_s + CTR_W'(1));
      end else begin
         ctr_nxt_s = (ctr_cur_s == CTR_ZERO) ? ctr_cur_s : (ctr_cur_s - CTR_W'(1));
      end
   end

   // Next-state for the table and statistics; flush outranks any update.
   always_comb begin
      valid_d     = valid_q;
      tag_d       = tag_q;
      target_d    = target_q;
      ctr_d       = ctr_q;
      stat_upd_d  = stat_upd_q;
      stat_miss_d = stat_miss_q;
      upd_hit_s   = valid_q[upd_idx_s] && (tag_q[upd_idx_s] == upd_tag_s);
      if (flush && !stall) begin
         valid_d = {ENTRIES{1'b0}};
      end else if (accept_s) begin
         stat_upd_d  = stat_upd_q + 32'd1;
         stat_miss_d = stat_miss_q + {31'd0, upd_mispredict};
         if (upd_hit_s) begin
            ctr_d[upd_idx_s] = ctr_nxt_s;
            if (upd_taken) begin
               target_d[upd_idx_s] = upd_target;
            end else begin
               target_d[upd_idx_s] = target_q[upd_idx_s];
            end
         end else if (upd_taken) begin
            valid_d[upd_idx_s]  = 1'b1;
            tag_d[upd_idx_s]    = upd_tag_s;
            target_d[upd_idx_s] = upd_target;
            ctr_d[upd_idx_s]    = CTR_WT;
         end else begin
            valid_d[upd_idx_s] = valid_q[upd_idx_s];
         end
      end else begin
         valid_d = valid_q;
      end
   end

   // Table and statistics registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q     <= {ENTRIES{1'b0}};
         stat_upd_q  <= 32'd0;
         stat_miss_q <= 32'd0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= {TAG_W{1'b0}};
            target_q[i] <= {ADDR_W{1'b0}};
            ctr_q[i]    <= CTR_WNT;
         end
      end else begin
         valid_q     <= valid_d;
         stat_upd_q  <= stat_upd_d;
         stat_miss_q <= stat_miss_d;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= tag_d[i];
            target_q[i] <= target_d[i];
            ctr_q[i]    <= ctr_d[i];
         end
      end
   end

   assign stat_upd  = stat_upd_q;
   assign stat_miss = stat_miss_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed scoreboard bench for branch_target_predictor (ENTRIES=16, CTR_W=2).
module tb_branch_target_predictor;

   localparam int IDX_W = 4;

   logic              clk = 1'b0;
   logic              rst, stall, flush;
   logic [31:0]       lk_pc;
   logic              lk_hit, lk_taken;
   logic [31:0]       lk_target;
   logic [IDX_W-1:0]  lk_ghr;
   logic              upd_valid, upd_taken, upd_mispredict;
   logic [31:0]       upd_pc, upd_target;
   logic [IDX_W-1:0]  upd_ghr;
   logic [31:0]       stat_upd, stat_miss;

   typedef struct {
      string            tag;
      logic             hit;
      logic             taken;
      logic [31:0]      tgt;
      logic [IDX_W-1:0] ghr;
      logic [31:0]      su;
      logic [31:0]      sm;
   } exp_t;

   exp_t        sb_q[$];
   int          n_assert = 0;
   int          n_fail   = 0;
   logic [31:0] exp_su   = 32'd0;
   logic [31:0] exp_sm   = 32'd0;

   localparam logic [31:0] PA = 32'h0040_0010;
   localparam logic [31:0] PB = 32'h0040_0050;
   localparam logic [31:0] PC = 32'h0040_0090;
   localparam logic [31:0] PD = 32'h0040_0020;
   localparam logic [31:0] T1 = 32'h0040_0100;
   localparam logic [31:0] T2 = 32'h0040_0200;
   localparam logic [31:0] T3 = 32'h0040_0300;

   branch_target_predictor #(.ADDR_W(32), .ENTRIES(16), .CTR_W(2)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .lk_pc(lk_pc), .lk_hit(lk_hit), .lk_taken(lk_taken), .lk_target(lk_target),
      .lk_ghr(lk_ghr), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
      .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
      .stat_upd(stat_upd), .stat_miss(stat_miss)
   );

   always #5 clk = ~clk;

   // One cycle: drive, push expectation, compare at negedge, advance the stats model.
   task automatic cyc(input logic uv, input logic [31:0] upc, input logic [IDX_W-1:0] ug,
                      input logic ut, input logic [31:0] utg, input logic um,
                      input logic st, input logic fl, input logic rs,
                      input logic [31:0] lpc, input logic eh, input logic et,
                      input logic [31:0] etg, input logic [IDX_W-1:0] eg, input string tag);
      exp_t e;
      upd_valid = uv; upd_pc = upc; upd_ghr = ug; upd_taken = ut; upd_target = utg;
      upd_mispredict = um; stall = st; flush = fl; rst = rs; lk_pc = lpc;
      sb_q.push_back('{tag, eh, et, etg, eg, exp_su, exp_sm});
      @(negedge clk);
      e = sb_q.pop_front();
      n_assert++;
      assert (lk_hit === e.hit) else begin
         n_fail++; $error("FAIL %s lk_hit observed %b expected %b", e.tag, lk_hit, e.hit);
      end
      n_assert++;
      assert (lk_taken === e.taken) else begin
         n_fail++; $error("FAIL %s lk_taken observed %b expected %b", e.tag, lk_taken, e.taken);
      end
      n_assert++;
      assert (lk_target === e.tgt) else begin
         n_fail++; $error("FAIL %s lk_target observed %h expected %h", e.tag, lk_target, e.tgt);
      end
      n_assert++;
      assert (lk_ghr === e.ghr) else begin
         n_fail++; $error("FAIL %s lk_ghr observed %h expected %h", e.tag, lk_ghr, e.ghr);
      end
      n_assert++;
      assert (stat_upd === e.su) else begin
         n_fail++; $error("FAIL %s stat_upd observed %0d expected %0d", e.tag, stat_upd, e.su);
      end
      n_assert++;
      assert (stat_miss === e.sm) else begin
         n_fail++; $error("FAIL %s stat_miss observed %0d expected %0d", e.tag, stat_miss, e.sm);
      end
      if (rs) begin
         exp_su = 32'd0; exp_sm = 32'd0;
      end else if (uv && !st && !fl) begin
         exp_su = exp_su + 32'd1; exp_sm = exp_sm + {31'd0, um};
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0; lk_pc = PA;
      upd_valid = 1'b0; upd_pc = 32'd0; upd_ghr = 4'd0; upd_taken = 1'b0;
      upd_target = 32'd0; upd_mispredict = 1'b0;
      repeat (2) @(posedge clk);
      #1;
`ifndef BTP_GSHARE_EN
      //  uv    upc  ug    ut    utg            um    st    fl    rs    lpc           eh    et    etg             eg
      cyc(1'b0, PA, 4'd0, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0, PA,           1'b0, 1'b0, PA + 32'd4,     4'd0, "reset");
      cyc(1'b0, PA, 4'd0, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'd0,          4'd0, "pc_wrap");
      cyc(1'b1, PA, 4'd0, 1'b1, T1,            1'b1, 1'b0, 1'b0, 1'b0, PA,           1'b0, 1'b0, PA + 32'd4,     4'd0, "same_cycle");
      cyc(1'b0, PA, 4'd0, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0, PA,           1'b1, 1'b1, T1,             4'd0, "alloc");
      cyc(1'b1, PA, 4'd0, 1'b1, T1,            1'b0, 1'b0, 1'b0, 1'b0, PA,           1'b1, 1'b1, T1,             4'd0, "sat1");
      cyc(1'b1, PA, 4'd0, 1'b1, T1,            1'b0, 1'b0, 1'b0, 1'b0, PA,           1'b1, 1'b1, T1,             4'd0, "sat2");
      cyc(1'b1, PA, 4'd0, 1'b1, T1,            1'b0, 1'b0, 1'b0, 1'b0, PA,           1'b1, 1'b1, T1,             4'd0, "sat3");
      cyc(1'b1, PA, 4'd0, 1'b0, 32'hDEAD_0000, 1'b1, 1'b0, 1'b0, 1'b0, PA,           1'b1, 1'b1, T1,             4'd0, "nt1");
      cyc(1'b1, PA, 4'd0, 1'b0, 32'hDEAD_0000, 1'b0, 1'b0, 1'b0, 1'b0, PA,           1'b1, 1'b1, T1,             4'd0, "nt2");
      cyc(1'b0, PA, 4'd0, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0, PA,           1'b1, 1'b0, PA + 32'd4,     4'd0, "weak_nt");
      cyc(1'b1, PA, 4'd0, 1'b1, T2,            1'b1, 1'b0, 1'b0, 1'b0, PA,           1'b1, 1'b0, PA + 32'd4,     4'd0, "retrain");
      cyc(1'b0, PA, 4'd0, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0, PA,           1'b1, 1'b1, T2,             4'd0, "new_target");
      cyc(1'b1, PB, 4'd0, 1'b1, T3,            1'b1, 1'b0, 1'b0, 1'b0, PA,           1'b1, 1'b1, T2,             4'd0, "alias_upd");
      cyc(1'b0, PA, 4'd0, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0, PA,           1'b0, 1'b0, PA + 32'd4,     4'd0, "alias_evict");
      cyc(1'b0, PA, 4'd0, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0, PB,           1'b1, 1'b1, T3,             4'd0, "alias_new");
      cyc(1'b1, PC, 4'd0, 1'b0, 32'h1111_0000, 1'b0, 1'b0, 1'b0, 1'b0, PC,           1'b0, 1'b0, PC + 32'd4,     4'd0, "nt_miss");
      cyc(1'b0, PA, 4'd0, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0, PB,           1'b1, 1'b1, T3,             4'd0, "nt_miss_keep");
      cyc(1'b0, PA, 4'd0, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0, PC,           1'b0, 1'b0, PC + 32'd4,     4'd0, "nt_miss_noalloc");
      cyc(1'b1, PD, 4'd0, 1'b1, T1,            1'b1, 1'b1, 1'b0, 1'b0, PB,           1'b1, 1'b1, T3,             4'd0, "stall_live");
      cyc(1'b0, PA, 4'd0, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0, PD,           1'b0, 1'b0, PD + 32'd4,     4'd0, "stall_frozen");
      cyc(1'b1, PD, 4'd0, 1'b1, T1,            1'b1, 1'b0, 1'b1, 1'b0, PB,           1'b1, 1'b1, T3,             4'd0, "flush_cycle");
      cyc(1'b0, PA, 4'd0, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0, PB,           1'b0, 1'b0, PB + 32'd4,     4'd0, "flush_B");
      cyc(1'b0, PA, 4'd0, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0, PD,           1'b0, 1'b0, PD + 32'd4,     4'd0, "flush_D");
      cyc(1'b1, PD, 4'd0, 1'b1, T1,            1'b0, 1'b0, 1'b0, 1'b0, PD,           1'b0, 1'b0, PD + 32'd4,     4'd0, "post_flush_upd");
      cyc(1'b0, PA, 4'd0, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0, PD,           1'b1, 1'b1, T1,             4'd0, "post_flush_hit");
      cyc(1'b1, PA, 4'd0, 1'b1, T2,            1'b1, 1'b0, 1'b0, 1'b1, PD,           1'b1, 1'b1, T1,             4'd0, "rst_mid");
      cyc(1'b0, PA, 4'd0, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0, PD,           1'b0, 1'b0, PD + 32'd4,     4'd0, "rst_after_D");
      cyc(1'b0, PA, 4'd0, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0, PA,           1'b0, 1'b0, PA + 32'd4,     4'd0, "rst_after_A");
`else
      cyc(1'b0, PA, 4'd0, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0, PA,           1'b0, 1'b0, PA + 32'd4,     4'd0, "g_reset");
      cyc(1'b1, PA, 4'd0, 1'b1, T1,            1'b1, 1'b0, 1'b0, 1'b0, PA,           1'b0, 1'b0, PA + 32'd4,     4'd0, "g_train");
      cyc(1'b0, PA, 4'd0, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0, PA,           1'b0, 1'b0, PA + 32'd4,     4'd1, "g_idx5_miss");
      cyc(1'b0, PA, 4'd0, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0014, 1'b1, 1'b1, T1,            4'd1, "g_idx4_hit");
      cyc(1'b1, PA, 4'd0, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0, PA,           1'b0, 1'b0, PA + 32'd4,     4'd1, "g_nt_upd");
      cyc(1'b0, PA, 4'd0, 1'b0, 32'd0,         1'b0, 1'b0, 1'b1, 1'b0, PA,           1'b0, 1'b0, PA + 32'd4,     4'd2, "g_flush");
      cyc(1'b0, PA, 4'd0, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0, PA,           1'b0, 1'b0, PA + 32'd4,     4'd2, "g_ghr_kept");
      cyc(1'b0, PA, 4'd0, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 1'b1, PA,           1'b0, 1'b0, PA + 32'd4,     4'd2, "g_rst");
      cyc(1'b0, PA, 4'd0, 1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 1'b0, PA,           1'b0, 1'b0, PA + 32'd4,     4'd0, "g_ghr_clr");
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
